ws2812b_rx: RTL and testbench
=============================

Name: ws2812b_rx

Overview:
- WS2812B single-wire receiver/decoder, the counterpart of the existing WS2812B output driver.
- Samples a serial WS2812B stream, classifies each high pulse as bit 0 or 1, and assembles 24-bit GRB pixels MSB first.
- Detects the low-time latch (reset) and reports frame boundaries.
- Used for loopback self-test of the LED-matrix path (driver output wired to receiver input) and for monitoring an upstream controller.

Parameters:
- THRESH_CYCLES, 7: a high pulse of at least this many clk cycles decodes as 1; shorter decodes as 0.
- MAX_HIGH_CYCLES, 30: a high pulse reaching this length is a protocol error.
- RESET_CYCLES, 600: continuous low time, in clk cycles, that constitutes a latch (50 us at 12 MHz).
- IDX_W, 6: width of the pixel index (64-pixel matrix).

Ports:
- clk, input, 1: system clock, 12 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, 1: raw WS2812B serial input, asynchronous to clk.
- pixel_data, output, 24: last complete pixel {G,R,B}, MSB first on the wire.
- pixel_valid, output, 1: one-cycle pulse when pixel_data updates.
- pixel_index, output, IDX_W: index of the pixel in pixel_data within the current frame.
- frame_done, output, 1: one-cycle pulse on a latch that follows at least one pixel.
- err, output, 1: one-cycle pulse on a protocol error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Synchronizer flops 0, counters 0.
  - State WAIT_RESET.
  - Reset asserted mid-pixel discards the partial pixel with no pulses.
- din passes through a 2-FF synchronizer to give din_s. Everything below operates on din_s.
- State machine:
  - WAIT_RESET: din_s must stay low for RESET_CYCLES consecutive cycles before decoding starts. Any high restarts the count. On completion go to LOW, with no frame_done.
  - LOW: low_cnt counts. A rising din_s enters HIGH with high_cnt = 1. low_cnt reaching RESET_CYCLES is a latch (see below); stay in LOW and hold low_cnt saturated.
  - HIGH: high_cnt increments and saturates at MAX_HIGH_CYCLES.
    - Falling din_s: bit = (high_cnt >= THRESH_CYCLES). Shift it into the shift register, increment bit_cnt, go to LOW with low_cnt = 1.
    - high_cnt reaching MAX_HIGH_CYCLES: err pulses, the partial pixel is discarded (bit_cnt = 0), go to ERROR.
  - ERROR: wait for din_s low, then go to WAIT_RESET.
- Pixel completion:
  - On the falling edge that delivers bit 24: pixel_data <= shift register, pixel_valid pulses, pixel_index <= pix_cnt, pix_cnt increments, bit_cnt = 0.
  - Latency: pixel_valid is high exactly 3 clk after the raw din falling edge (2 sync + 1 register).
  - pixel_data and pixel_index hold until the next completion.
- pix_cnt wraps modulo 2^IDX_W. There is no error on wrap.
- Latch (low_cnt == RESET_CYCLES in LOW):
  - If bit_cnt != 0: err pulses and the partial pixel is discarded.
  - frame_done pulses iff at least one pixel has completed since the previous latch.
  - pix_cnt = 0.
  - Both pulses may occur in the same cycle.
  - The latch fires exactly once per low period.
- Boundary pulse lengths:
  - high_cnt == THRESH_CYCLES-1 decodes as 0.
  - high_cnt == THRESH_CYCLES decodes as 1.
  - high_cnt == MAX_HIGH_CYCLES-1 is a valid 1.
- Low time between bits has no minimum. A 1-cycle low followed by high is a legal bit boundary.

Optional Feature:
- Macro: WS2812B_RX_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority filter follows the synchronizer; din_s is the filtered value.
  - An isolated 1-cycle spike or dropout is removed.
  - All latencies grow by 1 (pixel_valid 4 clk after the raw falling edge).
- Undefined: no filter; latencies as stated above.

Decomposition:
- Package ws2812b_pkg holds:
  - the default timing constants, also reused by the driver (T0H = 5, T1H = 10, TBIT = 15 cycles, RESET = 600);
  - the receiver state enum typedef (WAIT_RESET, LOW, HIGH, ERROR);
  - the typedef for the 24-bit GRB pixel.
- One sub-module, ws2812b_rx_sync: the 2-FF synchronizer plus the optional majority filter. It outputs din_s.

Test Plan:
- Startup:
  - Stimulus: after reset, drive a pixel with no preceding 600-cycle low.
  - Required: no pixel_valid. After 600 low cycles, pixel 0xFF00A5 (1 = 10H/5L, 0 = 5H/10L) gives pixel_valid with pixel_data = 0xFF00A5, pixel_index = 0.
- Frame:
  - Stimulus: 64 pixels with value = index*0x040201, then 600 low cycles.
  - Required: 64 pixel_valid pulses with indices 0..63 and correct data. Exactly one frame_done, 600 cycles after the last falling edge plus sync latency. err never asserts.
- Threshold:
  - Stimulus: bits with high widths of 6 and 7 cycles.
  - Required: they decode as 0 and 1 respectively.
- Error paths:
  - Stimulus 1: a 30-cycle high pulse in mid-pixel.
    - Required: err pulses once; no pixel_valid until a 600-cycle low and a new full pixel.
  - Stimulus 2: 12 bits followed by 600 low cycles.
    - Required: err and (if a prior pixel exists) frame_done in the same cycle.
- Reset and wrap:
  - Stimulus 1: assert rst_n low after 20 bits, release, then send a full frame.
    - Required: first pixel_index = 0 and no stale bits in pixel_data.
  - Stimulus 2: 65 pixels in one frame.
    - Required: the 65th has pixel_index = 0.
- Glitch filter:
  - Build with WS2812B_RX_GLITCH_FILTER_EN.
  - Stimulus: a 1-cycle low dropout inside a 10-cycle high.
  - Required: decodes as a single 1, and pixel_valid latency is 4 clk.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// ---------------------------------------------------------------------------
// ws2812b_pkg
// Shared definitions for the WS2812B driver and receiver:
//   - default bit/latch timing constants in clk cycles (12 MHz clock)
//   - receiver state enum
//   - 24-bit GRB pixel typedef (G in the MSBs, sent first on the wire)
// ---------------------------------------------------------------------------
package ws2812b_pkg;

  // Driver-side waveform timing, also the nominal receive timing.
  localparam int T0H_CYCLES   = 5;
  localparam int T1H_CYCLES   = 10;
  localparam int TBIT_CYCLES  = 15;
  localparam int LATCH_CYCLES = 600;

  // Receiver decode defaults.
  localparam int THRESH_DEF   = 7;
  localparam int MAX_HIGH_DEF = 30;

  typedef enum logic [1:0] {
    WAIT_RESET,
    LOW,
    HIGH,
    ERROR
  } rx_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_pixel_t;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// ---------------------------------------------------------------------------
// ws2812b_rx_sync
// Brings the asynchronous WS2812B line into the clk domain.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   din    : raw serial input, asynchronous to clk
//   din_s  : synchronized (and optionally filtered) line level
// Optional macro WS2812B_RX_GLITCH_FILTER_EN adds a 3-sample majority vote
// after the 2-FF synchronizer, removing isolated 1-cycle spikes/dropouts at
// the cost of one extra cycle of latency.
// ---------------------------------------------------------------------------
module ws2812b_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef WS2812B_RX_GLITCH_FILTER_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  always_comb begin
    hist1_d = sync2_q;
    hist2_d = hist1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  // Majority of the three newest samples: a level change shows up one
  // cycle after it reaches sync2_q, and pulse widths are preserved.
  assign din_s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign din_s = sync2_q;
`endif

endmodule

// File: rtl/ws2812b_rx.sv
// ---------------------------------------------------------------------------
// ws2812b_rx
// WS2812B single-wire receiver: measures each high pulse, decodes it as a
// 0 or 1 bit, assembles 24-bit GRB pixels MSB first and detects the
// low-time latch that ends a frame.
//   clk         : system clock (12 MHz nominal)
//   rst_n       : asynchronous active-low reset
//   din         : raw serial input, asynchronous to clk
//   pixel_data  : last complete pixel {G,R,B}
//   pixel_valid : 1-cycle pulse when pixel_data/pixel_index update
//   pixel_index : position of pixel_data within the current frame
//   frame_done  : 1-cycle pulse on a latch that follows at least one pixel
//   err         : 1-cycle pulse on an over-long high or a partial pixel
// Optional macro WS2812B_RX_GLITCH_FILTER_EN (see ws2812b_rx_sync) adds a
// majority glitch filter and one cycle of latency.
// ---------------------------------------------------------------------------
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int THRESH_CYCLES   = THRESH_DEF,
  parameter int MAX_HIGH_CYCLES = MAX_HIGH_DEF,
  parameter int RESET_CYCLES    = LATCH_CYCLES,
  parameter int IDX_W           = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             err
);

  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH_CYCLES + 1);

  logic din_s;

  ws2812b_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .din_s (din_s)
  );

  rx_state_e        state_q, state_d;
  logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
  logic [HIGH_W-1:0] high_cnt_q, high_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [IDX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              got_pix_q, got_pix_d;   // a pixel completed since the last latch
  grb_pixel_t        pixel_data_q, pixel_data_d;
  logic [IDX_W-1:0]  pixel_index_q, pixel_index_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic [LOW_W-1:0]  low_inc;
  logic [HIGH_W-1:0] high_inc;
  logic              new_bit;
  logic [23:0]       shifted;

  assign low_inc  = low_cnt_q + 1'b1;
  assign high_inc = high_cnt_q + 1'b1;
  assign new_bit  = (high_cnt_q >= HIGH_W'(THRESH_CYCLES));
  assign shifted  = {shift_q[22:0], new_bit};

  always_comb begin
    state_d       = state_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pix_cnt_d     = pix_cnt_q;
    got_pix_d     = got_pix_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      WAIT_RESET: begin
        if (din_s) begin
          low_cnt_d = '0;
        end else if (low_inc == LOW_W'(RESET_CYCLES)) begin
          // Arrive in LOW already saturated so this low period cannot latch.
          state_d   = LOW;
          low_cnt_d = low_inc;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          got_pix_d = 1'b0;
        end else begin
          low_cnt_d = low_inc;
        end
      end

      LOW: begin
        if (din_s) begin
          state_d    = HIGH;
          high_cnt_d = HIGH_W'(1);
        end else if (low_cnt_q != LOW_W'(RESET_CYCLES)) begin
          low_cnt_d = low_inc;
          if (low_inc == LOW_W'(RESET_CYCLES)) begin
            err_d        = (bit_cnt_q != 5'd0);
            frame_done_d = got_pix_q;
            bit_cnt_d    = '0;
            pix_cnt_d    = '0;
            got_pix_d    = 1'b0;
          end
        end
      end

      HIGH: begin
        if (!din_s) begin
          state_d   = LOW;
          low_cnt_d = LOW_W'(1);
          shift_d   = shifted;
          if (bit_cnt_q == 5'd23) begin
            pixel_data_d  = grb_pixel_t'(shifted);
            pixel_index_d = pix_cnt_q;
            pixel_valid_d = 1'b1;
            pix_cnt_d     = pix_cnt_q + 1'b1;
            got_pix_d     = 1'b1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (high_inc == HIGH_W'(MAX_HIGH_CYCLES)) begin
          state_d    = ERROR;
          high_cnt_d = high_inc;
          err_d      = 1'b1;
          bit_cnt_d  = '0;
        end else begin
          high_cnt_d = high_inc;
        end
      end

      ERROR: begin
        if (!din_s) begin
          state_d   = WAIT_RESET;
          low_cnt_d = '0;
        end
      end

      default: state_d = WAIT_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_RESET;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pix_cnt_q     <= '0;
      got_pix_q     <= 1'b0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pix_cnt_q     <= pix_cnt_d;
      got_pix_q     <= got_pix_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// ---------------------------------------------------------------------------
// tb_ws2812b_rx
// Directed and randomized WS2812B waveforms; a monitor logs every output
// pulse with its cycle number, and the expected pixels, indices and pulse
// times are derived from the waveform that was sent.
// ---------------------------------------------------------------------------
module tb_ws2812b_rx;

  localparam int THRESH = 7;
  localparam int MAXH   = 30;
  localparam int RST    = 600;
  localparam int IDX_W  = 6;
`ifdef WS2812B_RX_GLITCH_FILTER_EN
  localparam int LAT  = 4;
  localparam int MINW = 2;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic             err;

  ws2812b_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulses
  logic [23:0] pv_data[$];
  int          pv_idx[$];
  int          pv_cyc[$];
  int          fd_cyc[$];
  int          err_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        pv_data.push_back(pixel_data);
        pv_idx.push_back(int'(pixel_index));
        pv_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (err) err_cyc.push_back(cyc);
    end
  end

  // Reference model state
  logic [23:0] exp_data[$];
  int          exp_idx[$];
  int          frame_pix = 0;
  int          last_fall = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    pv_data.delete(); pv_idx.delete(); pv_cyc.delete();
    fd_cyc.delete(); err_cyc.delete();
    exp_data.delete(); exp_idx.delete();
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int hw, input int lw);
    hold(1'b1, hw);
    last_fall = cyc;
    hold(1'b0, lw);
  endtask

  task automatic push_expected(input logic [23:0] val);
    exp_data.push_back(val);
    exp_idx.push_back(frame_pix % (1 << IDX_W));
    frame_pix++;
  endtask

  task automatic send_pixel(input logic [23:0] val, input int h1, input int l1,
                            input int h0, input int l0);
    for (int b = 23; b >= 0; b--) begin
      if (val[b]) send_bit(h1, l1);
      else        send_bit(h0, l0);
    end
    push_expected(val);
  endtask

  task automatic send_std(input logic [23:0] val);
    send_pixel(val, 10, 5, 5, 10);
  endtask

  // Random widths on both sides of the threshold; the bit value follows
  // from the measured width alone.
  task automatic send_random_pixel();
    logic [23:0] v;
    int hw;
    for (int b = 23; b >= 0; b--) begin
      if ($urandom_range(1, 0) == 1) hw = $urandom_range(MAXH - 1, THRESH);
      else                           hw = $urandom_range(THRESH - 1, MINW);
      v[b] = (hw >= THRESH);
      send_bit(hw, $urandom_range(12, MINW));
    end
    push_expected(v);
  endtask

  task automatic latch_low();
    hold(1'b0, RST + 100);
    frame_pix = 0;
  endtask

  task automatic check_pixels(input string tag);
    int n;
    chk($sformatf("%s_count", tag), pv_data.size(), exp_data.size());
    n = (pv_data.size() < exp_data.size()) ? pv_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), pv_data[i], exp_data[i]);
      chk($sformatf("%s_idx%0d", tag, i), pv_idx[i], exp_idx[i]);
    end
  endtask

  initial begin
    int rise;
    logic [23:0] v;

    // ---- reset state ----
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", pixel_data, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_index", pixel_index, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // ---- startup: pixels before any 600-cycle low are ignored ----
    clear_all();
    hold(1'b0, 3);
    send_std(24'h123456);
    hold(1'b0, 50);
    send_std(24'h654321);
    latch_low();
    chk("startup_nopv", pv_data.size(), 0);
    chk("startup_nofd", fd_cyc.size(), 0);
    chk("startup_noerr", err_cyc.size(), 0);

    clear_all();
    send_std(24'hFF00A5);
    hold(1'b0, 20);
    check_pixels("startup");
    if (pv_cyc.size() > 0) chk("startup_lat", pv_cyc[0], last_fall + LAT);
    latch_low();
    chk("startup_fd_n", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) chk("startup_fd_cyc", fd_cyc[0], last_fall + LAT + RST - 1);
    chk("startup_err", err_cyc.size(), 0);
    chk("startup_hold_data", pixel_data, 24'hFF00A5);
    chk("startup_hold_idx", pixel_index, 0);

    // ---- full 64-pixel frame ----
    clear_all();
    for (int i = 0; i < 64; i++) send_std(24'(i * 24'h040201));
    latch_low();
    check_pixels("frame");
    if (pv_cyc.size() > 0) chk("frame_lat", pv_cyc[pv_cyc.size() - 1], last_fall + LAT);
    chk("frame_fd_n", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) chk("frame_fd_cyc", fd_cyc[0], last_fall + LAT + RST - 1);
    chk("frame_err", err_cyc.size(), 0);

    // ---- threshold boundaries: 6 -> 0, 7 -> 1, 29 -> 1, minimal low gaps ----
    clear_all();
    for (int b = 23; b >= 0; b--) begin
      if (b == 23)      send_bit(MAXH - 1, MINW);
      else if (b == 22) send_bit(MINW, MINW);
      else if (b % 2)   send_bit(THRESH, MINW);
      else              send_bit(THRESH - 1, MINW);
    end
    push_expected(24'hAAAAAA);
    latch_low();
    check_pixels("thresh");
    chk("thresh_err", err_cyc.size(), 0);
    chk("thresh_fd", fd_cyc.size(), 1);

    // ---- randomized frames ----
    for (int f = 0; f < 3; f++) begin
      int np;
      clear_all();
      np = $urandom_range(4, 1);
      for (int p = 0; p < np; p++) send_random_pixel();
      latch_low();
      check_pixels($sformatf("rand%0d", f));
      chk($sformatf("rand%0d_fd", f), fd_cyc.size(), 1);
      chk($sformatf("rand%0d_err", f), err_cyc.size(), 0);
    end

    // ---- error path 1: over-long high in mid-pixel ----
    clear_all();
    for (int b = 0; b < 10; b++) send_bit(10, 5);
    rise = cyc;
    hold(1'b1, MAXH);
    hold(1'b0, 20);
    send_std(24'h777777);
    exp_data.delete(); exp_idx.delete(); frame_pix = 0;
    hold(1'b0, 20);
    chk("err1_nopv", pv_data.size(), 0);
    chk("err1_n", err_cyc.size(), 1);
    if (err_cyc.size() > 0) chk("err1_cyc", err_cyc[0], rise + LAT + MAXH - 1);
    latch_low();
    chk("err1_nofd", fd_cyc.size(), 0);
    send_std(24'h5A5A5A);
    hold(1'b0, 20);
    check_pixels("err1_recover");
    latch_low();
    chk("err1_fd", fd_cyc.size(), 1);
    chk("err1_err_total", err_cyc.size(), 1);

    // ---- error path 2: partial pixel then latch ----
    clear_all();
    send_std(24'h0F0F0F);
    for (int b = 0; b < 12; b++) send_bit(10, 5);
    latch_low();
    check_pixels("err2");
    chk("err2_err_n", err_cyc.size(), 1);
    chk("err2_fd_n", fd_cyc.size(), 1);
    if (err_cyc.size() > 0) chk("err2_err_cyc", err_cyc[0], last_fall + LAT + RST - 1);
    if (fd_cyc.size() > 0)  chk("err2_fd_cyc", fd_cyc[0], last_fall + LAT + RST - 1);

    // ---- reset in mid-pixel ----
    clear_all();
    for (int b = 0; b < 20; b++) send_bit(10, 5);
    rst_n = 1'b0;
    hold(1'b0, 3);
    chk("midrst_data", pixel_data, 0);
    chk("midrst_idx", pixel_index, 0);
    rst_n = 1'b1;
    frame_pix = 0;
    latch_low();
    send_std(24'h00000F);
    send_std(24'hC3C3C3);
    latch_low();
    check_pixels("midrst");
    chk("midrst_fd", fd_cyc.size(), 1);
    chk("midrst_err", err_cyc.size(), 0);

    // ---- index wrap: 65 pixels in one frame ----
    clear_all();
    for (int i = 0; i < 65; i++) begin
      v = 24'($urandom);
      send_pixel(v, 8, 2, 3, 2);
    end
    latch_low();
    check_pixels("wrap");
    if (pv_idx.size() == 65) chk("wrap_idx64", pv_idx[64], 0);
    chk("wrap_fd", fd_cyc.size(), 1);
    chk("wrap_err", err_cyc.size(), 0);

`ifdef WS2812B_RX_GLITCH_FILTER_EN
    // ---- glitch filter: 1-cycle dropouts in highs, 1-cycle spikes in lows ----
    clear_all();
    v = 24'hC35A96;
    for (int b = 23; b >= 0; b--) begin
      if (v[b]) begin
        hold(1'b1, 4); hold(1'b0, 1); hold(1'b1, 5);
        last_fall = cyc;
        hold(1'b0, 5);
      end else begin
        hold(1'b1, 5);
        last_fall = cyc;
        hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 6);
      end
    end
    push_expected(v);
    hold(1'b0, 20);
    check_pixels("glitch");
    if (pv_cyc.size() > 0) chk("glitch_lat", pv_cyc[0], last_fall + 4);
    latch_low();
    chk("glitch_err", err_cyc.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
